// File: rtl/onchip_memory_pipelined_if.sv
// Avalon-MM slave bundle for onchip_memory_pipelined.
// Carries request, clock-enable, reset-request and pipelined read response.
interface onchip_memory_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_SIZE;

  logic                  chipselect;
  logic [ADDR_WIDTH-1:0] address;
  logic [NB-1:0]         byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic                  reset_req;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, address, byteenable,
    output read, write, writedata,
    output clken, reset_req,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, address, byteenable,
    input  read, write, writedata,
    input  clken, reset_req,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_memory_pipelined.sv
// Single-port Avalon-MM RAM, byte-lane writes, 1/2-cycle pipelined reads.
// Define ONCHIP_MEM_CLEAR_EN to zero-fill the array after every reset.
module onchip_memory_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input logic clk,
  input logic reset_n,
  onchip_memory_pipelined_if.slave bus
);
  localparam int NB = DATA_WIDTH / BYTE_SIZE;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rst_done;
  logic                  in_range;
  logic [IW-1:0]         idx;
  logic                  accept;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  assign bus.waitrequest = ~rst_done | ~bus.clken | bus.reset_req;

  assign in_range = {1'b0, bus.address} < DEPTH_W;
  assign idx      = bus.address[IW-1:0];
  assign accept   = bus.chipselect & (bus.read | bus.write)
                  & ~bus.waitrequest;
  // write wins when both strobes are high
  assign wr_fire  = accept & bus.write;
  assign rd_fire  = accept & bus.read & ~bus.write;
  assign rd_word  = in_range ? mem[idx] : '0;

`ifdef ONCHIP_MEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] cnt;
  logic          clr_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (clr_we)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR:
        if (clr_we && cnt == IW'(DEPTH - 1))
          state_nx = READY;
      READY: state_nx = READY;
    endcase
  end

  always_comb begin
    clr_we   = 1'b0;
    rst_done = 1'b0;
    unique case (state)
      CLEAR: clr_we   = bus.clken;
      READY: rst_done = 1'b1;
    endcase
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rst_done <= 1'b0;
    else
      rst_done <= 1'b1;
  end
`endif

  // storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
`ifdef ONCHIP_MEM_CLEAR_EN
    if (clr_we)
      mem[cnt] <= '0;
    else
`endif
    if (wr_fire && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byteenable[i])
          mem[idx][i*BYTE_SIZE +: BYTE_SIZE] <=
            bus.writedata[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  logic                  in_v;
  logic [DATA_WIDTH-1:0] in_d;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign in_v = rd_fire;
      assign in_d = rd_word;
    end else begin : g_lat2
      logic                  s1_v;
      logic [DATA_WIDTH-1:0] s1_d;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_v <= 1'b0;
          s1_d <= '0;
        end else if (bus.clken) begin
          s1_v <= rd_fire;
          if (rd_fire)
            s1_d <= rd_word;
        end
      end

      assign in_v = s1_v;
      assign in_d = s1_d;
    end
  endgenerate

  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;
  logic [DATA_WIDTH-1:0] last_d;

  // last_d keeps readdata steady while a beat sits stalled in out_d
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_v  <= 1'b0;
      out_d  <= '0;
      last_d <= '0;
    end else if (bus.clken) begin
      out_v <= in_v;
      if (in_v)
        out_d <= in_d;
      if (out_v)
        last_d <= out_d;
    end
  end

  assign bus.readdatavalid = out_v & bus.clken;
  assign bus.readdata      = bus.readdatavalid ? out_d : last_d;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Randomised bench for onchip_memory_pipelined against a queue-based model.
// Directed test-plan sequences first, then free-running random traffic.
module tb_onchip_memory_pipelined;
  localparam int DW    = 32;
  localparam int BS    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int LAT   = 2;
  localparam int NB    = DW / BS;

  typedef struct {
    int            k;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  onchip_memory_pipelined_if #(
    .DATA_WIDTH(DW), .BYTE_SIZE(BS), .ADDR_WIDTH(AW)
  ) bus ();

  onchip_memory_pipelined #(
    .DATA_WIDTH(DW), .BYTE_SIZE(BS), .ADDR_WIDTH(AW),
    .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [DEPTH];
  beat_t         q [$];
  logic [DW-1:0] m_last;
  logic          m_done;
  int            m_cnt;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    reset_n        = 1'b0;
    #1;
    chk("rst_wait", 64'(bus.waitrequest), 64'd1);
    chk("rst_valid", 64'(bus.readdatavalid), 64'd0);
    chk("rst_data", 64'(bus.readdata), 64'd0);
    q.delete();
    m_last = '0;
    m_done = 1'b0;
    m_cnt  = 0;
`ifdef ONCHIP_MEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic cs, input logic rd,
                      input logic wr, input logic [AW-1:0] a,
                      input logic [NB-1:0] be,
                      input logic [DW-1:0] wd,
                      input logic ce, input logic rr);
    logic exp_wait;
    logic vis;
    logic acc;
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = wd;
    bus.clken      = ce;
    bus.reset_req  = rr;
    #1;
    exp_wait = !m_done || !ce || rr;
    vis = (q.size() > 0) && (q[0].k == 0);
    chk("waitreq", 64'(bus.waitrequest), 64'(exp_wait));
    chk("rdvalid", 64'(bus.readdatavalid), 64'(ce && vis));
    chk("rddata", 64'(bus.readdata),
        64'((ce && vis) ? q[0].d : m_last));
    acc = cs && (rd || wr) && !exp_wait;
    @(posedge clk);
    if (ce) begin
      if (vis) begin
        m_last = q[0].d;
        void'(q.pop_front());
      end
      foreach (q[i]) if (q[i].k > 0) q[i].k--;
    end
    if (acc && wr) begin
      if (int'(a) < DEPTH)
        for (int i = 0; i < NB; i++)
          if (be[i]) m_mem[a][i*BS +: BS] = wd[i*BS +: BS];
    end else if (acc && rd) begin
      q.push_back('{k: LAT - 1,
                    d: (int'(a) < DEPTH) ? m_mem[a] : '0});
    end
`ifdef ONCHIP_MEM_CLEAR_EN
    if (!m_done && ce) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_done = 1'b1;
    end
`else
    m_done = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic wr_op(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic [NB-1:0] be);
    step(1'b1, 1'b0, 1'b1, a, be, d, 1'b1, 1'b0);
  endtask

  task automatic rd_op(input logic [AW-1:0] a);
    step(1'b1, 1'b1, 1'b0, a, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.byteenable = '0;
    bus.writedata  = '0;
    bus.clken      = 1'b1;
    bus.reset_req  = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    #1;
    do_reset();
`ifdef ONCHIP_MEM_CLEAR_EN
    idle(7);
    do_reset();
    idle(DEPTH + 2);
    for (int i = 0; i < DEPTH; i += 7) rd_op(AW'(i));
    idle(LAT + 1);
`else
    idle(2);
`endif

    for (int i = 0; i < DEPTH; i++)
      wr_op(AW'(i), DW'(i) * 32'h0101_0101 ^ 32'h5A00_00C3, 4'hF);

    wr_op(8'd5, 32'hDEAD_BEEF, 4'hF);
    rd_op(8'd5);
    idle(LAT + 1);

    wr_op(8'd3, 32'hFFFF_FFFF, 4'hF);
    wr_op(8'd3, 32'h0000_0012, 4'b0001);
    rd_op(8'd3);
    wr_op(8'd9, 32'h1234_5678, 4'h0);
    rd_op(8'd9);
    idle(LAT + 1);

    for (int i = 0; i < 4; i++)
      wr_op(AW'(i), 32'hA0 + DW'(i), 4'hF);
    rd_op(8'd0);
    rd_op(8'd1);
    step(1'b1, 1'b1, 1'b0, 8'd2, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd2, '0, '0, 1'b0, 1'b0);
    rd_op(8'd2);
    rd_op(8'd3);
    idle(LAT + 2);

    rd_op(8'd7);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 8'd8, '0, '0, 1'b1, 1'b1);
    rd_op(8'd8);
    idle(LAT + 1);

    wr_op(8'd210, 32'hCAFE_F00D, 4'hF);
    rd_op(8'd210);
    rd_op(8'd10);
    step(1'b1, 1'b1, 1'b1, 8'd11, 4'hF, 32'h7777_0000, 1'b1, 1'b0);
    rd_op(8'd11);
    idle(LAT + 1);

    rd_op(8'd5);
    do_reset();
    idle(DEPTH + 2);
    rd_op(8'd5);
    rd_op(8'd3);
    idle(LAT + 1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 2) == 0),
             AW'($urandom_range(0, 255)),
             NB'($urandom),
             DW'($urandom),
             1'($urandom_range(0, 6) != 0),
             1'($urandom_range(0, 19) == 0));
      end
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
